// File: rtl/intr_ctrl_pkg.sv
// intr_ctrl_pkg
// Shared definitions for the interrupt controller: FSM state encoding and
// the default source count / source-id width.
// Build option: INTR_CTRL_SYNC_EN (see intr_ctrl.sv).
package intr_ctrl_pkg;

    localparam int N_SRC_DEF = 8;
    localparam int ID_W_DEF  = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_SERVICE = 2'd2
    } state_t;

endpackage

// File: rtl/intr_prio_enc.sv
// intr_prio_enc
// Combinational fixed-priority encoder: the lowest-index set bit wins.
// Ports:
//   i_req   [N_SRC] request vector (pending & mask)
//   o_valid         any bit set
//   o_id    [ID_W]  index of the lowest set bit (0 when none)
module intr_prio_enc #(
    parameter int N_SRC = 8,
    parameter int ID_W  = 3
) (
    input  logic [N_SRC-1:0] i_req,
    output logic             o_valid,
    output logic [ID_W-1:0]  o_id
);

    // Scan from the top down so the last assignment is the lowest index.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// intr_ctrl
// Edge-triggered, maskable interrupt controller in front of cop0. Rising
// edges on i_irq latch into a pending register; the lowest-index pending and
// enabled source is requested through o_external_interrupt. The core takes
// the exception (i_ack), which clears that pending bit and puts the source in
// service until i_eret. No nesting: one source in service at a time.
//
// Handshake: o_external_interrupt is a level held while in REQ; i_ack is a
// one-cycle pulse that is only honoured in REQ, i_eret a one-cycle pulse only
// honoured in SERVICE. Pulses in other states are ignored.
//
// Build option: define INTR_CTRL_SYNC_EN to put a 2-flop synchronizer on each
// i_irq bit (request latency 4 cycles instead of 2).
//
// Ports:
//   i_clk, i_rst_n          clock, async active-low reset
//   i_irq        [N_SRC]    peripheral request levels
//   i_mask_we, i_mask_data  mask register write (1 = enabled)
//   i_ack, i_eret           exception taken / eret executed
//   o_external_interrupt    request to cop0 (state REQ)
//   o_irq_id     [ID_W]     requested / in-service source id
//   o_pending    [N_SRC]    pending register
//   o_mask       [N_SRC]    mask register
//   o_busy                  state SERVICE
//   o_dbg_state  [2]        FSM state (debug observation)
module intr_ctrl
    import intr_ctrl_pkg::*;
#(
    parameter int N_SRC = N_SRC_DEF,
    parameter int ID_W  = ID_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [N_SRC-1:0] i_irq,
    input  logic             i_mask_we,
    input  logic [N_SRC-1:0] i_mask_data,
    input  logic             i_ack,
    input  logic             i_eret,
    output logic             o_external_interrupt,
    output logic [ID_W-1:0]  o_irq_id,
    output logic [N_SRC-1:0] o_pending,
    output logic [N_SRC-1:0] o_mask,
    output logic             o_busy,
    output logic [1:0]       o_dbg_state
);

    state_t             state, state_nxt;
    logic [ID_W-1:0]    id_nxt;
    logic               ack_take;
    logic [N_SRC-1:0]   irq_s;
    logic [N_SRC-1:0]   irq_prev;
    logic [N_SRC-1:0]   rise;
    logic [N_SRC-1:0]   ack_clr;
    logic               win_valid;
    logic [ID_W-1:0]    win_id;

`ifdef INTR_CTRL_SYNC_EN
    logic [N_SRC-1:0] sync1, sync2;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= i_irq;
            sync2 <= sync1;
        end
    end

    assign irq_s = sync2;
`else
    assign irq_s = i_irq;
`endif

    // Edge registers reset to 0, so a line already high at reset release is
    // seen as an event; firmware masks or clears it.
    assign rise = irq_s & ~irq_prev;

    intr_prio_enc #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_prio (
        .i_req   (o_pending & o_mask),
        .o_valid (win_valid),
        .o_id    (win_id)
    );

    always_comb begin
        state_nxt = state;
        id_nxt    = o_irq_id;
        ack_take  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (win_valid) begin
                    state_nxt = ST_REQ;
                    id_nxt    = win_id;
                end
            end
            ST_REQ: begin
                if (!win_valid) begin
                    state_nxt = ST_IDLE;
                end else if (i_ack) begin
                    // id frozen: it names the source now in service
                    state_nxt = ST_SERVICE;
                    ack_take  = 1'b1;
                end else begin
                    id_nxt = win_id;
                end
            end
            ST_SERVICE: begin
                if (i_eret) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        ack_clr = '0;
        if (ack_take) ack_clr[o_irq_id] = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            o_irq_id  <= '0;
            o_pending <= '0;
            o_mask    <= '1;
            irq_prev  <= '0;
        end else begin
            state     <= state_nxt;
            o_irq_id  <= id_nxt;
            // A new edge on the bit being acked wins over the clear.
            o_pending <= (o_pending & ~ack_clr) | rise;
            irq_prev  <= irq_s;
            if (i_mask_we) o_mask <= i_mask_data;
        end
    end

    assign o_external_interrupt = (state == ST_REQ);
    assign o_busy               = (state == ST_SERVICE);
    assign o_dbg_state          = state;

endmodule

// File: tb/tb_intr_ctrl.sv
// tb_intr_ctrl
// Self-checking bench for intr_ctrl (8 sources). Follows INTR_CTRL_SYNC_EN to
// pick the expected request latency.
module tb_intr_ctrl;

`ifdef INTR_CTRL_SYNC_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 2;
`endif

    logic       i_clk;
    logic       i_rst_n;
    logic [7:0] i_irq;
    logic       i_mask_we;
    logic [7:0] i_mask_data;
    logic       i_ack;
    logic       i_eret;
    logic       o_external_interrupt;
    logic [2:0] o_irq_id;
    logic [7:0] o_pending;
    logic [7:0] o_mask;
    logic       o_busy;
    logic [1:0] o_dbg_state;

    int errors = 0;
    int checks = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_id;

    intr_ctrl #(.N_SRC(8), .ID_W(3)) dut (
        .i_clk                (i_clk),
        .i_rst_n              (i_rst_n),
        .i_irq                (i_irq),
        .i_mask_we            (i_mask_we),
        .i_mask_data          (i_mask_data),
        .i_ack                (i_ack),
        .i_eret               (i_eret),
        .o_external_interrupt (o_external_interrupt),
        .o_irq_id             (o_irq_id),
        .o_pending            (o_pending),
        .o_mask               (o_mask),
        .o_busy               (o_busy),
        .o_dbg_state          (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic pulse_ack();
        i_ack = 1'b1;
        step();
        i_ack = 1'b0;
    endtask

    task automatic pulse_eret();
        i_eret = 1'b1;
        step();
        i_eret = 1'b0;
    endtask

    task automatic write_mask(input logic [7:0] m);
        i_mask_we   = 1'b1;
        i_mask_data = m;
        step();
        i_mask_we   = 1'b0;
    endtask

    // Bounded wait for the request line; returns 0 on timeout.
    task automatic wait_req(output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (o_external_interrupt === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
    endtask

    // Wait for a request and compare its id with the scoreboard head.
    task automatic expect_req(input string name);
        bit ok;
        wait_req(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout got=no request exp=request", name);
        end
        exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 3'd0;
        checks++;
        if (o_irq_id !== exp_id) begin
            errors++;
            $display("FAIL %s_id got=%0d exp=%0d", name, o_irq_id, exp_id);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        i_rst_n = 1'b0;
        steps(2);
        checks++;
        if ({o_external_interrupt, o_irq_id, o_pending, o_mask, o_busy, o_dbg_state}
            !== {1'b0, 3'd0, 8'h00, 8'hFF, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL reset_values got=ext%b id%0d pend%h mask%h busy%b st%0d",
                     o_external_interrupt, o_irq_id, o_pending, o_mask, o_busy, o_dbg_state);
        end
        i_rst_n = 1'b1;
        steps(3);
        // ack/eret in IDLE are ignored
        pulse_ack();
        pulse_eret();
        checks++;
        if (o_dbg_state !== 2'd0 || o_pending !== 8'h00) begin
            errors++;
            $display("FAIL idle_ignore got=st%0d pend%h exp=st0 pend00", o_dbg_state, o_pending);
        end
    endtask

    task automatic test_basic();
        i_irq[5] = 1'b1;
        exp_q.push_back(3'd5);
        steps(LAT - 1);
        checks++;
        if (o_pending !== 8'h20 || o_external_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL basic_pending got=pend%h ext%b exp=pend20 ext0", o_pending, o_external_interrupt);
        end
        step();
        checks++;
        if (o_external_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency got=ext%b exp=ext1", o_external_interrupt);
        end
        expect_req("basic");
        steps(2);
        pulse_ack();
        checks++;
        if (o_busy !== 1'b1 || o_pending !== 8'h00 || o_external_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL basic_ack got=busy%b pend%h ext%b exp=busy1 pend00 ext0",
                     o_busy, o_pending, o_external_interrupt);
        end
        // a second ack in SERVICE is ignored
        pulse_ack();
        checks++;
        if (o_busy !== 1'b1 || o_irq_id !== 3'd5) begin
            errors++;
            $display("FAIL service_ack_ignore got=busy%b id%0d exp=busy1 id5", o_busy, o_irq_id);
        end
        steps(3);
        pulse_eret();
        checks++;
        if (o_dbg_state !== 2'd0 || o_busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_eret got=st%0d busy%b exp=st0 busy0", o_dbg_state, o_busy);
        end
        i_irq = '0;
        steps(4);
    endtask

    task automatic test_priority();
        i_irq[3] = 1'b1;
        i_irq[6] = 1'b1;
        exp_q.push_back(3'd3);
        exp_q.push_back(3'd6);
        expect_req("prio_first");
        pulse_ack();
        checks++;
        if (o_pending !== 8'h40 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL prio_ack got=pend%h busy%b exp=pend40 busy1", o_pending, o_busy);
        end
        pulse_eret();
        checks++;
        if (o_external_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL prio_gap got=ext%b exp=ext0", o_external_interrupt);
        end
        step();
        checks++;
        if (o_external_interrupt !== 1'b1) begin
            errors++;
            $display("FAIL prio_second_latency got=ext%b exp=ext1", o_external_interrupt);
        end
        expect_req("prio_second");
        // eret in REQ is ignored
        pulse_eret();
        checks++;
        if (o_external_interrupt !== 1'b1 || o_irq_id !== 3'd6) begin
            errors++;
            $display("FAIL req_eret_ignore got=ext%b id%0d exp=ext1 id6", o_external_interrupt, o_irq_id);
        end
        pulse_ack();
        pulse_eret();
        i_irq = '0;
        steps(4);
    endtask

    task automatic test_mask();
        write_mask(8'hFB);
        checks++;
        if (o_mask !== 8'hFB) begin
            errors++;
            $display("FAIL mask_load got=%h exp=fb", o_mask);
        end
        i_irq[2] = 1'b1;
        steps(LAT + 2);
        checks++;
        if (o_pending !== 8'h04 || o_external_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL mask_block got=pend%h ext%b exp=pend04 ext0", o_pending, o_external_interrupt);
        end
        write_mask(8'hFF);
        exp_q.push_back(3'd2);
        expect_req("mask_release");
        pulse_ack();
        pulse_eret();
        i_irq = '0;
        steps(4);
    endtask

    task automatic test_overtake();
        i_irq[4] = 1'b1;
        exp_q.push_back(3'd4);
        expect_req("overtake_first");
        i_irq[1] = 1'b1;
        steps(LAT);
        exp_q.push_back(3'd1);
        expect_req("overtake_new");
        pulse_ack();
        checks++;
        if (o_pending !== 8'h10 || o_irq_id !== 3'd1) begin
            errors++;
            $display("FAIL overtake_ack got=pend%h id%0d exp=pend10 id1", o_pending, o_irq_id);
        end
        pulse_eret();
        exp_q.push_back(3'd4);
        expect_req("overtake_resume");
        pulse_ack();
        pulse_eret();
        i_irq = '0;
        steps(4);
    endtask

    // New edge and ack-clear on the same bit at the same edge; the set wins and
    // the bit then waits through SERVICE without raising a request.
    task automatic test_same_edge();
        i_irq[0] = 1'b1;
        exp_q.push_back(3'd0);
        expect_req("same_first");
        i_irq[0] = 1'b0;
        steps(LAT + 1);
        i_irq[0] = 1'b1;
        steps(LAT - 2);
        pulse_ack();
        checks++;
        if (o_pending !== 8'h01 || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL same_edge got=pend%h busy%b exp=pend01 busy1", o_pending, o_busy);
        end
        i_irq[7] = 1'b1;
        steps(LAT + 2);
        checks++;
        if (o_pending !== 8'h81 || o_external_interrupt !== 1'b0) begin
            errors++;
            $display("FAIL service_latch got=pend%h ext%b exp=pend81 ext0", o_pending, o_external_interrupt);
        end
        pulse_eret();
        exp_q.push_back(3'd0);
        expect_req("same_after");
        pulse_ack();
        pulse_eret();
        exp_q.push_back(3'd7);
        expect_req("same_seven");
        pulse_ack();
        pulse_eret();
        i_irq = '0;
        steps(4);
    endtask

    task automatic test_reset_mid();
        i_irq[6] = 1'b1;
        exp_q.push_back(3'd6);
        expect_req("rstmid");
        pulse_ack();
        i_irq[2] = 1'b1;
        write_mask(8'hFE);
        steps(LAT);
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_external_interrupt, o_irq_id, o_pending, o_mask, o_busy}
            !== {1'b0, 3'd0, 8'h00, 8'hFF, 1'b0}) begin
            errors++;
            $display("FAIL reset_mid got=ext%b id%0d pend%h mask%h busy%b",
                     o_external_interrupt, o_irq_id, o_pending, o_mask, o_busy);
        end
        i_irq = '0;
        steps(2);
        i_rst_n = 1'b1;
        steps(8);
        checks++;
        if (o_external_interrupt !== 1'b0 || o_pending !== 8'h00 || o_dbg_state !== 2'd0) begin
            errors++;
            $display("FAIL reset_release got=ext%b pend%h st%0d exp=ext0 pend00 st0",
                     o_external_interrupt, o_pending, o_dbg_state);
        end
    endtask

    task automatic test_random();
        int src;
        for (int n = 0; n < 8; n++) begin
            src = $urandom_range(0, 7);
            i_irq[src] = 1'b1;
            exp_q.push_back(3'(src));
            expect_req("rand");
            steps($urandom_range(0, 3));
            pulse_ack();
            checks++;
            if (o_pending !== 8'h00 || o_busy !== 1'b1) begin
                errors++;
                $display("FAIL rand_ack src=%0d got=pend%h busy%b exp=pend00 busy1", src, o_pending, o_busy);
            end
            steps($urandom_range(0, 3));
            pulse_eret();
            i_irq = '0;
            steps(4);
        end
    endtask

    // ---------------- main sequence / report ----------------
    initial begin
        i_rst_n     = 1'b0;
        i_irq       = '0;
        i_mask_we   = 1'b0;
        i_mask_data = '0;
        i_ack       = 1'b0;
        i_eret      = 1'b0;
        test_reset();
        test_basic();
        test_priority();
        test_mask();
        test_overtake();
        test_same_edge();
        test_reset_mid();
        test_random();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d left exp=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
